core_ex_fu_ctrl: RTL and testbench
==================================

Name: core_ex_fu_ctrl

Overview:
- Parametrised execute-stage controller and successor to the single-LSU execute unit.
- Accepts one decoded op per cycle and dispatches it to one of NUM_FU functional-unit channels (ALU, LSU, MDU, ...). Each channel has its own valid/ready/done/ack handshake and variable latency.
- Tracks up to DEPTH in-flight ops in a tag queue and retires them strictly in program order to the register-file writeback port.
- Raises a one-cycle pipeline flush on a redirecting completion, and provides RAW-hazard and forwarding outputs to decode.

Parameters:
- NUM_FU, 3, number of functional-unit channels (2..8).
- DEPTH, 4, in-flight queue entries (power of two, 2..16).
- XLEN, 32, data width.
- RFIDX_W, 5, register index width.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  decoded op valid.
- ready_in  out  1  controller can accept op.
- i_fu_sel  in  NUM_FU  one-hot target channel.
- i_rd_wen  in  1  op writes rd.
- i_rd_idx  in  RFIDX_W  destination register.
- i_rs1_idx  in  RFIDX_W  decode-stage source 1, for hazard check.
- i_rs2_idx  in  RFIDX_W  decode-stage source 2, for hazard check.
- fu_valid  out  NUM_FU  dispatch strobe per channel.
- fu_ready  in  NUM_FU  channel accepts dispatch.
- fu_done  in  NUM_FU  channel holds a completed result for its oldest op.
- fu_ack  out  NUM_FU  controller consumed that result.
- fu_result  in  NUM_FU*XLEN  per-channel result, channel k at bits [k*XLEN +: XLEN].
- fu_redirect  in  NUM_FU  completed op requests redirect (mispredict).
- fu_redirect_pc  in  NUM_FU*PC_W  per-channel redirect target.
- fu_kill  out  1  discard all in-flight work in every channel.
- wb_en  out  1  writeback strobe.
- wb_idx  out  RFIDX_W  writeback register.
- wb_data  out  XLEN  writeback data.
- cmt_pipeline_flush_req  out  1  flush upstream stages.
- cmt_flush_pc  out  PC_W  flush target.
- raw_hazard  out  1  i_rs1_idx/i_rs2_idx matches a non-forwardable in-flight rd.
- rd_wen_ex_forward  out  1  forwarding valid, equal to wb_en.
- rd_idx_ex_forward  out  RFIDX_W  equal to wb_idx.
- rd_dat_ex_forward  out  XLEN  equal to wb_data.
- exu_busy  out  1  queue non-empty.

Behaviour:
- Reset:
  - Queue empty; head/tail pointers and count are 0.
  - ready_in=1. All of fu_valid, fu_ack, fu_kill, wb_en, cmt_pipeline_flush_req, raw_hazard and exu_busy are 0.
  - cmt_flush_pc, wb_idx and wb_data are 0.
  - Reset asserted mid-operation abandons all entries immediately. No ack or kill is issued.
- Queue entry: {fu one-hot, rd_wen, rd_idx}, DEPTH entries, circular pointers of width clog2(DEPTH) that wrap modulo DEPTH, count of width clog2(DEPTH)+1.
- Dispatch:
  - fu_valid = valid_in & i_fu_sel & {NUM_FU{~full & ~flush_cycle}}.
  - ready_in = ~full & ~flush_cycle & |(i_fu_sel & fu_ready).
  - Accept = valid_in & ready_in. On accept the entry is pushed at tail in the same cycle. Zero-cycle dispatch latency; op visible to hazard logic next cycle.
  - An illegal i_fu_sel (not one-hot) is never accepted; ready_in=0.
- Retire:
  - Combinational on head. If count!=0 and fu_done[head.fu]: fu_ack[head.fu]=1, wb_en=head.rd_wen & (rd_idx!=0), wb_idx=head.rd_idx, wb_data=fu_result of head channel. Pop head.
  - Done from a non-head channel is ignored (no ack); that channel holds its result.
- Simultaneous push and pop: count unchanged, both pointers advance. Full with pop in the same cycle does NOT admit a push; ready_in uses registered full.
- Redirect:
  - When a retiring head has fu_redirect[head.fu]=1, the retire and writeback still occur.
  - Next cycle (registered, flush_cycle=1): cmt_pipeline_flush_req=1 for exactly one cycle, cmt_flush_pc = the captured redirect PC, fu_kill=1 for that cycle.
  - In that cycle the queue is cleared (head=tail, count=0) and ready_in=0.
  - Completions arriving during flush_cycle are not acked; channels drop them on fu_kill.
- Hazard:
  - raw_hazard=1 if any valid non-retiring entry has rd_wen, rd_idx!=0 and rd_idx equal to i_rs1_idx or i_rs2_idx.
  - The entry retiring this cycle is excluded because it is covered by the forward outputs.
- exu_busy = (count!=0), registered.

Decomposition:
- core_defines.v gains the macros CORE_NUM_FU, CORE_EXQ_DEPTH and the FU index constants CORE_FU_ALU=0, CORE_FU_LSU=1 and CORE_FU_MDU=2.
- One sub-module, core_ex_tag_fifo: a parametrised circular queue with push, pop and clear, exposing full, empty, head entry and a flat entry vector for the hazard compare.
- Flops use gnrl_dffr/gnrl_dfflr.

Test Plan:
- Back-to-back ALU ops, each with a one-cycle done on channel 0:
  - Sequence: push x5=rd, one cycle later fu_result[0]=0x11.
  - Required: wb_en=1, wb_idx=5, wb_data=0x11. Throughput is one per cycle and count never exceeds 1.
- Out-of-order completion:
  - Sequence: LSU op to x6, then ALU op to x7. ALU done asserts first, LSU done three cycles later with 0xAA.
  - Required: no ack to the ALU until the x6 writeback of 0xAA. x7 retires the next cycle.
- Full queue:
  - Sequence: push 4 LSU ops with fu_done held low.
  - Required: ready_in=0 after the 4th push. Asserting done pops one op; ready_in=1 the following cycle.
- Redirect:
  - Sequence: head has fu_redirect with pc=0x8000_0040, and 2 younger entries are queued.
  - Required: the head still writes back. Next cycle cmt_pipeline_flush_req=1 with cmt_flush_pc=0x8000_0040 and fu_kill=1, and exu_busy=0 after that.
- Hazard:
  - Sequence: in-flight LSU op to x9, decode presents rs2=9.
  - Required: raw_hazard=1. In the retire cycle raw_hazard=0 and rd_dat_ex_forward equals the load data. rd=x0 never raises a hazard or wb_en.
- Reset mid-stream:
  - Sequence: pull rst_n low with 3 entries queued.
  - Required: all outputs return to reset values asynchronously, and ready_in=1 after release.

Source files
------------

// File: rtl/core_ex_fu_ctrl_pkg.sv
// Shared constants and types for the execute-stage functional-unit controller.
// Default channel count, queue depth and the fixed channel index assignment live here.
package core_ex_fu_ctrl_pkg;

    localparam int CORE_NUM_FU    = 3;
    localparam int CORE_EXQ_DEPTH = 4;
    localparam int CORE_FU_ALU    = 0;
    localparam int CORE_FU_LSU    = 1;
    localparam int CORE_FU_MDU    = 2;
    localparam int CORE_FU_MAX    = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    // Channel selects are zero-extended to CORE_FU_MAX bits before this check.
    function automatic logic is_onehot(input logic [CORE_FU_MAX-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/core_ex_fu_ctrl_if.sv
// Bundle of per-channel handshake, result and redirect signals between the
// controller (master) and the functional units (slave).
interface core_ex_fu_ctrl_if #(
    parameter int NUM_FU = 3,
    parameter int XLEN   = 32,
    parameter int PC_W   = 32
);
    logic [NUM_FU-1:0]      fu_valid;
    logic [NUM_FU-1:0]      fu_ready;
    logic [NUM_FU-1:0]      fu_done;
    logic [NUM_FU-1:0]      fu_ack;
    logic [NUM_FU*XLEN-1:0] fu_result;
    logic [NUM_FU-1:0]      fu_redirect;
    logic [NUM_FU*PC_W-1:0] fu_redirect_pc;
    logic                   fu_kill;

    modport master (
        output fu_valid, fu_ack, fu_kill,
        input  fu_ready, fu_done, fu_result, fu_redirect, fu_redirect_pc
    );

    modport slave (
        input  fu_valid, fu_ack, fu_kill,
        output fu_ready, fu_done, fu_result, fu_redirect, fu_redirect_pc
    );
endinterface

// File: rtl/core_ex_fu_ctrl_tag_fifo.sv
// Circular in-flight tag queue with push, pop and clear; exposes the head entry
// plus every slot and its occupancy so the owner can run hazard compares.
module core_ex_tag_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clr,
    input  logic [W-1:0]               i_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH)-1:0]   o_head_ptr,
    output logic [DEPTH-1:0]           o_slot_valid,
    output logic [DEPTH*W-1:0]         o_entries
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // Clearing parks head on tail so any stale slot contents stay invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PTR_W'(1);
            if (i_pop)  r_head <= r_head + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clr) r_mem[r_tail] <= i_data;
    end

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_head     = r_mem[r_head];
    assign o_head_ptr = r_head;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] w_off;
            assign w_off                 = PTR_W'(gi) - r_head;
            assign o_slot_valid[gi]      = ({1'b0, w_off} < r_count);
            assign o_entries[gi*W +: W]  = r_mem[gi];
        end
    endgenerate

endmodule

// File: rtl/core_ex_fu_ctrl.sv
// Execute-stage controller: dispatches decoded ops to one of NUM_FU channels,
// retires them in program order to writeback, and handles redirect flushes.
module core_ex_fu_ctrl
    import core_ex_fu_ctrl_pkg::*;
#(
    parameter int NUM_FU  = CORE_NUM_FU,
    parameter int DEPTH   = CORE_EXQ_DEPTH,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    output logic               ready_in,
    input  logic [NUM_FU-1:0]  i_fu_sel,
    input  logic               i_rd_wen,
    input  logic [RFIDX_W-1:0] i_rd_idx,
    input  logic [RFIDX_W-1:0] i_rs1_idx,
    input  logic [RFIDX_W-1:0] i_rs2_idx,
    core_ex_fu_ctrl_if.master  fu_bus,
    output logic               wb_en,
    output logic [RFIDX_W-1:0] wb_idx,
    output logic [XLEN-1:0]    wb_data,
    output logic               cmt_pipeline_flush_req,
    output logic [PC_W-1:0]    cmt_flush_pc,
    output logic               raw_hazard,
    output logic               rd_wen_ex_forward,
    output logic [RFIDX_W-1:0] rd_idx_ex_forward,
    output logic [XLEN-1:0]    rd_dat_ex_forward,
    output logic               exu_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = NUM_FU + 1 + RFIDX_W;

    flush_state_e         r_state;
    flush_state_e         w_state_next;
    logic                 w_flush_cycle;
    logic [PC_W-1:0]      r_flush_pc;

    logic                 w_full;
    logic                 w_empty;
    logic [ENT_W-1:0]     w_head;
    logic [PTR_W-1:0]     w_head_ptr;
    logic [DEPTH-1:0]     w_slot_valid;
    logic [DEPTH*ENT_W-1:0] w_entries;

    logic [CORE_FU_MAX-1:0] w_sel_ext;
    logic                 w_sel_ok;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_redirect;
    logic [NUM_FU-1:0]    w_head_fu;
    logic                 w_head_wen;
    logic [RFIDX_W-1:0]   w_head_rd;
    logic [XLEN-1:0]      w_head_data;
    logic [PC_W-1:0]      w_head_pc;
    logic [DEPTH-1:0]     w_slot_hit;

    always_comb begin
        w_sel_ext               = '0;
        w_sel_ext[NUM_FU-1:0]   = i_fu_sel;
    end
    assign w_sel_ok = is_onehot(w_sel_ext);

    assign ready_in        = ~w_full & ~w_flush_cycle & w_sel_ok & (|(i_fu_sel & fu_bus.fu_ready));
    assign fu_bus.fu_valid = i_fu_sel & {NUM_FU{valid_in & ~w_full & ~w_flush_cycle}};
    assign w_push          = valid_in & ready_in;

    assign w_head_fu  = w_head[ENT_W-1 -: NUM_FU];
    assign w_head_wen = w_head[RFIDX_W];
    assign w_head_rd  = w_head[RFIDX_W-1:0];

    // The head is one-hot, so OR-ing masked channel buses acts as a mux.
    always_comb begin
        w_head_data = '0;
        w_head_pc   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (w_head_fu[k]) begin
                w_head_data = w_head_data | fu_bus.fu_result[k*XLEN +: XLEN];
                w_head_pc   = w_head_pc   | fu_bus.fu_redirect_pc[k*PC_W +: PC_W];
            end
        end
    end

    assign w_pop         = ~w_empty & ~w_flush_cycle & (|(w_head_fu & fu_bus.fu_done));
    assign w_redirect    = w_pop & (|(w_head_fu & fu_bus.fu_redirect));
    assign fu_bus.fu_ack = w_head_fu & {NUM_FU{w_pop}};

    assign wb_en   = w_pop & w_head_wen & (w_head_rd != '0);
    assign wb_idx  = w_pop ? w_head_rd   : '0;
    assign wb_data = w_pop ? w_head_data : '0;

    assign rd_wen_ex_forward = wb_en;
    assign rd_idx_ex_forward = wb_idx;
    assign rd_dat_ex_forward = wb_data;

    core_ex_tag_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_clr        (w_flush_cycle),
        .i_data       ({i_fu_sel, i_rd_wen, i_rd_idx}),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head       (w_head),
        .o_head_ptr   (w_head_ptr),
        .o_slot_valid (w_slot_valid),
        .o_entries    (w_entries)
    );

    // The slot retiring this cycle is served by the forward path instead.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_haz
            logic [ENT_W-1:0] w_ent;
            logic             w_retiring;
            assign w_ent      = w_entries[gi*ENT_W +: ENT_W];
            assign w_retiring = w_pop & (w_head_ptr == PTR_W'(gi));
            assign w_slot_hit[gi] = w_slot_valid[gi] & ~w_retiring & w_ent[RFIDX_W]
                                  & (w_ent[RFIDX_W-1:0] != '0)
                                  & ((w_ent[RFIDX_W-1:0] == i_rs1_idx) |
                                     (w_ent[RFIDX_W-1:0] == i_rs2_idx));
        end
    endgenerate
    assign raw_hazard = |w_slot_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_flush_pc <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_redirect) r_flush_pc <= w_head_pc;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_flush_cycle = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_redirect) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_flush_cycle = 1'b1;
                w_state_next  = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    assign fu_bus.fu_kill         = w_flush_cycle;
    assign cmt_pipeline_flush_req = w_flush_cycle;
    assign cmt_flush_pc           = r_flush_pc;
    assign exu_busy               = ~w_empty;

endmodule

// File: tb/tb_core_ex_fu_ctrl.sv
// Directed scoreboard bench for core_ex_fu_ctrl: stimulus queues expected
// retirements and flushes, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_core_ex_fu_ctrl;
    localparam int NUM_FU  = 3;
    localparam int DEPTH   = 4;
    localparam int XLEN    = 32;
    localparam int RFIDX_W = 5;
    localparam int PC_W    = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in;
    logic               ready_in;
    logic [NUM_FU-1:0]  i_fu_sel;
    logic               i_rd_wen;
    logic [RFIDX_W-1:0] i_rd_idx;
    logic [RFIDX_W-1:0] i_rs1_idx;
    logic [RFIDX_W-1:0] i_rs2_idx;
    logic               wb_en;
    logic [RFIDX_W-1:0] wb_idx;
    logic [XLEN-1:0]    wb_data;
    logic               cmt_pipeline_flush_req;
    logic [PC_W-1:0]    cmt_flush_pc;
    logic               raw_hazard;
    logic               rd_wen_ex_forward;
    logic [RFIDX_W-1:0] rd_idx_ex_forward;
    logic [XLEN-1:0]    rd_dat_ex_forward;
    logic               exu_busy;

    always #5 clk = ~clk;

    core_ex_fu_ctrl_if #(.NUM_FU(NUM_FU), .XLEN(XLEN), .PC_W(PC_W)) fu_if ();

    core_ex_fu_ctrl #(
        .NUM_FU(NUM_FU), .DEPTH(DEPTH), .XLEN(XLEN), .RFIDX_W(RFIDX_W), .PC_W(PC_W)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .valid_in               (valid_in),
        .ready_in               (ready_in),
        .i_fu_sel               (i_fu_sel),
        .i_rd_wen               (i_rd_wen),
        .i_rd_idx               (i_rd_idx),
        .i_rs1_idx              (i_rs1_idx),
        .i_rs2_idx              (i_rs2_idx),
        .fu_bus                 (fu_if.master),
        .wb_en                  (wb_en),
        .wb_idx                 (wb_idx),
        .wb_data                (wb_data),
        .cmt_pipeline_flush_req (cmt_pipeline_flush_req),
        .cmt_flush_pc           (cmt_flush_pc),
        .raw_hazard             (raw_hazard),
        .rd_wen_ex_forward      (rd_wen_ex_forward),
        .rd_idx_ex_forward      (rd_idx_ex_forward),
        .rd_dat_ex_forward      (rd_dat_ex_forward),
        .exu_busy               (exu_busy)
    );

    typedef struct packed {
        logic [NUM_FU-1:0]  ack;
        logic               wen;
        logic [RFIDX_W-1:0] idx;
        logic [XLEN-1:0]    data;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    logic [31:0] flush_q[$];
    wb_exp_t     mon_e;
    logic [31:0] mon_pc;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [NUM_FU-1:0] ack, input logic wen,
                            input logic [RFIDX_W-1:0] idx, input logic [XLEN-1:0] data);
        wb_exp_t e;
        e.ack = ack; e.wen = wen; e.idx = idx; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one line per retirement or flush, compared against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fu_if.fu_ack != '0 || wb_en) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected: ack=%b wb_en=%b idx=%0d data=0x%0h, none required",
                             fu_if.fu_ack, wb_en, wb_idx, wb_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("retire ack=%b wb_en=%b idx=%0d data=0x%0h", fu_if.fu_ack, wb_en, wb_idx, wb_data);
                    chk("wb_ack",   64'(fu_if.fu_ack), 64'(mon_e.ack));
                    chk("wb_en",    64'(wb_en),        64'(mon_e.wen));
                    chk("wb_idx",   64'(wb_idx),       64'(mon_e.idx));
                    chk("wb_data",  64'(wb_data),      64'(mon_e.data));
                    chk("fwd_wen",  64'(rd_wen_ex_forward), 64'(mon_e.wen));
                    chk("fwd_idx",  64'(rd_idx_ex_forward), 64'(mon_e.idx));
                    chk("fwd_data", 64'(rd_dat_ex_forward), 64'(mon_e.data));
                end
            end
            if (cmt_pipeline_flush_req) begin
                if (flush_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL flush_unexpected: pc=0x%0h, none required", cmt_flush_pc);
                end else begin
                    mon_pc = flush_q.pop_front();
                    $display("flush pc=0x%0h kill=%b", cmt_flush_pc, fu_if.fu_kill);
                    chk("flush_pc",   64'(cmt_flush_pc),  64'(mon_pc));
                    chk("flush_kill", 64'(fu_if.fu_kill), 64'd1);
                end
            end
        end
    end

    initial begin
        valid_in = 1'b0; i_fu_sel = 3'b001; i_rd_wen = 1'b0; i_rd_idx = '0;
        i_rs1_idx = '0; i_rs2_idx = '0;
        fu_if.fu_ready = '1; fu_if.fu_done = '0; fu_if.fu_result = '0;
        fu_if.fu_redirect = '0; fu_if.fu_redirect_pc = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ready",    64'(ready_in), 64'd1);
        chk("rst_fu_valid", 64'(fu_if.fu_valid), 64'd0);
        chk("rst_fu_ack",   64'(fu_if.fu_ack), 64'd0);
        chk("rst_fu_kill",  64'(fu_if.fu_kill), 64'd0);
        chk("rst_wb_en",    64'(wb_en), 64'd0);
        chk("rst_flush",    64'(cmt_pipeline_flush_req), 64'd0);
        chk("rst_hazard",   64'(raw_hazard), 64'd0);
        chk("rst_busy",     64'(exu_busy), 64'd0);
        chk("rst_flush_pc", 64'(cmt_flush_pc), 64'd0);
        chk("rst_wb_idx",   64'(wb_idx), 64'd0);
        chk("rst_wb_data",  64'(wb_data), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // Back-to-back ALU ops, each completing one cycle after dispatch
        for (int i = 0; i < 5; i++) begin
            valid_in = (i < 4); i_fu_sel = 3'b001; i_rd_wen = 1'b1; i_rd_idx = 5'd5;
            fu_if.fu_done = (i > 0) ? 3'b001 : 3'b000;
            fu_if.fu_result[31:0] = 32'h10 + 32'(i);
            if (i > 0) push_exp(3'b001, 1'b1, 5'd5, 32'h10 + 32'(i));
            @(negedge clk);
            if (i < 4) begin
                chk("s1_ready",    64'(ready_in), 64'd1);
                chk("s1_fu_valid", 64'(fu_if.fu_valid), 64'd1);
            end
            tick();
        end
        valid_in = 1'b0; fu_if.fu_done = '0;
        @(negedge clk);
        chk("s1_idle_busy", 64'(exu_busy), 64'd0);
        tick();

        // Out-of-order completion: ALU finishes before the older LSU op
        valid_in = 1'b1; i_fu_sel = 3'b010; i_rd_wen = 1'b1; i_rd_idx = 5'd6;
        @(negedge clk); chk("s2_ready_lsu", 64'(ready_in), 64'd1); tick();
        i_fu_sel = 3'b001; i_rd_idx = 5'd7;
        @(negedge clk); tick();
        valid_in = 1'b0;
        fu_if.fu_done = 3'b001; fu_if.fu_result[31:0] = 32'h77;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("s2_no_early_ack", 64'(fu_if.fu_ack), 64'd0);
            tick();
        end
        fu_if.fu_done = 3'b011; fu_if.fu_result[63:32] = 32'hAA;
        push_exp(3'b010, 1'b1, 5'd6, 32'hAA);
        @(negedge clk); tick();
        fu_if.fu_done = 3'b001;
        push_exp(3'b001, 1'b1, 5'd7, 32'h77);
        @(negedge clk); tick();
        fu_if.fu_done = '0;
        @(negedge clk); chk("s2_idle_busy", 64'(exu_busy), 64'd0); tick();

        // Full queue: four LSU ops with no completions
        valid_in = 1'b1; i_fu_sel = 3'b010; i_rd_wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_rd_idx = 5'(10 + i);
            @(negedge clk); chk("s3_ready_fill", 64'(ready_in), 64'd1); tick();
        end
        i_rd_idx = 5'd20;
        @(negedge clk);
        chk("s3_ready_full",    64'(ready_in), 64'd0);
        chk("s3_fu_valid_full", 64'(fu_if.fu_valid), 64'd0);
        tick();
        fu_if.fu_done = 3'b010; fu_if.fu_result[63:32] = 32'hB0;
        push_exp(3'b010, 1'b1, 5'd10, 32'hB0);
        @(negedge clk); chk("s3_ready_pop_cycle", 64'(ready_in), 64'd0); tick();
        valid_in = 1'b0; fu_if.fu_done = '0;
        @(negedge clk); chk("s3_ready_after_pop", 64'(ready_in), 64'd1); tick();
        for (int i = 1; i < 4; i++) begin
            fu_if.fu_done = 3'b010; fu_if.fu_result[63:32] = 32'hB0 + 32'(i);
            push_exp(3'b010, 1'b1, 5'(10 + i), 32'hB0 + 32'(i));
            @(negedge clk); tick();
        end
        fu_if.fu_done = '0;
        @(negedge clk); chk("s3_drained_busy", 64'(exu_busy), 64'd0); tick();

        // Redirect from the head with two younger entries queued
        valid_in = 1'b1; i_rd_wen = 1'b1;
        i_fu_sel = 3'b001; i_rd_idx = 5'd3; @(negedge clk); tick();
        i_fu_sel = 3'b010; i_rd_idx = 5'd4; @(negedge clk); tick();
        i_fu_sel = 3'b100; i_rd_idx = 5'd8; @(negedge clk); tick();
        valid_in = 1'b0; i_fu_sel = 3'b001;
        fu_if.fu_done = 3'b001; fu_if.fu_result[31:0] = 32'h33;
        fu_if.fu_redirect = 3'b001; fu_if.fu_redirect_pc[31:0] = 32'h8000_0040;
        push_exp(3'b001, 1'b1, 5'd3, 32'h33);
        flush_q.push_back(32'h8000_0040);
        @(negedge clk); tick();
        fu_if.fu_done = 3'b010; fu_if.fu_result[63:32] = 32'h44; fu_if.fu_redirect = '0;
        @(negedge clk);
        chk("s4_ready_flush", 64'(ready_in), 64'd0);
        chk("s4_kill",        64'(fu_if.fu_kill), 64'd1);
        chk("s4_flush_req",   64'(cmt_pipeline_flush_req), 64'd1);
        tick();
        fu_if.fu_done = '0;
        @(negedge clk);
        chk("s4_busy_after",      64'(exu_busy), 64'd0);
        chk("s4_flush_one_cycle", 64'(cmt_pipeline_flush_req), 64'd0);
        chk("s4_kill_after",      64'(fu_if.fu_kill), 64'd0);
        chk("s4_ready_after",     64'(ready_in), 64'd1);
        tick();

        // RAW hazard against an in-flight load, then forwarding on retire
        valid_in = 1'b1; i_fu_sel = 3'b010; i_rd_wen = 1'b1; i_rd_idx = 5'd9;
        i_rs1_idx = 5'd3; i_rs2_idx = 5'd9;
        @(negedge clk); chk("s5_haz_dispatch_cycle", 64'(raw_hazard), 64'd0); tick();
        valid_in = 1'b0;
        @(negedge clk); chk("s5_haz_rs2", 64'(raw_hazard), 64'd1); tick();
        i_rs1_idx = 5'd4; i_rs2_idx = 5'd10;
        @(negedge clk); chk("s5_no_haz", 64'(raw_hazard), 64'd0); tick();
        i_rs2_idx = 5'd9;
        fu_if.fu_done = 3'b010; fu_if.fu_result[63:32] = 32'h5A5A_0001;
        push_exp(3'b010, 1'b1, 5'd9, 32'h5A5A_0001);
        @(negedge clk);
        chk("s5_haz_retire", 64'(raw_hazard), 64'd0);
        chk("s5_fwd_data",   64'(rd_dat_ex_forward), 64'h5A5A_0001);
        tick();
        fu_if.fu_done = '0;
        valid_in = 1'b1; i_fu_sel = 3'b001; i_rd_wen = 1'b1; i_rd_idx = 5'd0;
        i_rs1_idx = 5'd0; i_rs2_idx = 5'd0;
        @(negedge clk); tick();
        valid_in = 1'b0;
        @(negedge clk);
        chk("s5_x0_haz",  64'(raw_hazard), 64'd0);
        chk("s5_x0_busy", 64'(exu_busy), 64'd1);
        tick();
        fu_if.fu_done = 3'b001; fu_if.fu_result[31:0] = 32'h99;
        push_exp(3'b001, 1'b0, 5'd0, 32'h99);
        @(negedge clk); tick();
        fu_if.fu_done = '0;

        // Illegal (non one-hot) channel select is refused
        valid_in = 1'b1; i_fu_sel = 3'b011; i_rd_idx = 5'd12;
        @(negedge clk); chk("s6_illegal_ready", 64'(ready_in), 64'd0); tick();
        valid_in = 1'b0; i_fu_sel = 3'b001;
        @(negedge clk); chk("s6_illegal_busy", 64'(exu_busy), 64'd0); tick();

        // Reset asserted with three entries queued
        valid_in = 1'b1; i_fu_sel = 3'b001; i_rd_wen = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            i_rd_idx = 5'(i);
            @(negedge clk); tick();
        end
        valid_in = 1'b0;
        @(negedge clk);
        chk("s7_busy_before", 64'(exu_busy), 64'd1);
        #2 rst_n = 1'b0; fu_if.fu_done = 3'b001;
        #1;
        chk("s7_rst_busy",  64'(exu_busy), 64'd0);
        chk("s7_rst_ready", 64'(ready_in), 64'd1);
        chk("s7_rst_ack",   64'(fu_if.fu_ack), 64'd0);
        chk("s7_rst_wb_en", 64'(wb_en), 64'd0);
        chk("s7_rst_kill",  64'(fu_if.fu_kill), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1; fu_if.fu_done = '0;
        tick();
        @(negedge clk);
        chk("s7_ready_release", 64'(ready_in), 64'd1);
        chk("s7_busy_release",  64'(exu_busy), 64'd0);
        tick();

        chk("exp_q_empty",   64'(exp_q.size()), 64'd0);
        chk("flush_q_empty", 64'(flush_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
